// File: rtl/yam430_alu_seq.sv
// Sequencer for yam430 two-operand instructions: fetches both operands over one
// register-file read port, runs them through the shared ALU, writes back and updates C/Z/N/V.
module yam430_alu_seq #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned OPCODE_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      ready,
  input  logic [OPCODE_WIDTH-1:0]   opcode_in,
  input  logic [REG_ADDR_WIDTH-1:0] src_reg_in,
  input  logic [REG_ADDR_WIDTH-1:0] dst_reg_in,
  output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic                      reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  output logic [DATA_WIDTH-1:0]     alu_source,
  output logic [DATA_WIDTH-1:0]     alu_dest_in,
  output logic                      alu_carry_in,
  input  logic [DATA_WIDTH-1:0]     alu_dest_out,
  input  logic                      alu_carry_out,
  output logic [3:0]                flags,
  output logic                      done,
  output logic                      illegal
);

  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDC = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBC = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_DADD = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BIT  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(15);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SRC, S_RD_DST, S_EXEC, S_WB, S_ILL
  } state_e;

  state_e                    state_q, state_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_WIDTH-1:0]     src_op_q, src_op_d, dst_op_q, dst_op_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [3:0]                flags_q, flags_d;
  logic                      ready_q, ready_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [OPCODE_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic                      done_q, done_d;
  logic                      illegal_q, illegal_d;

  logic in_exec, s_msb, d_msb, r_msb, r_zero;

  // Operand captured in EXEC is taken straight from the read port so the ALU sees it this cycle.
  assign in_exec     = (state_q == S_EXEC);
  assign alu_source  = (in_exec && op_q == OP_MOV) ? reg_rd_data : src_op_q;
  assign alu_dest_in = in_exec ? ((op_q == OP_MOV) ? '0 : reg_rd_data) : dst_op_q;

  assign s_msb  = alu_source[DATA_WIDTH-1];
  assign d_msb  = alu_dest_in[DATA_WIDTH-1];
  assign r_msb  = alu_dest_out[DATA_WIDTH-1];
  assign r_zero = (alu_dest_out == '0);

  function automatic logic [OPCODE_WIDTH-1:0] map_op(input logic [OPCODE_WIDTH-1:0] op);
    if (op == OP_CMP)      return OP_SUB;
    else if (op == OP_BIT) return OP_AND;
    else                   return op;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      src_op_q  <= '0;
      dst_op_q  <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      ready_q   <= 1'b1;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      alu_op_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_op_q  <= src_op_d;
      dst_op_q  <= dst_op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      ready_q   <= ready_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      alu_op_q  <= alu_op_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state plus next values of every registered output, decoded from the next state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    src_op_d = src_op_q;
    dst_op_d = dst_op_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode_in;
          src_d = src_reg_in;
          dst_d = dst_reg_in;
          if (opcode_in < OPCODE_WIDTH'(4) || opcode_in == OP_DADD) state_d = S_ILL;
          else                                                       state_d = S_RD_SRC;
        end
      end
      S_RD_SRC: state_d = (op_q == OP_MOV) ? S_EXEC : S_RD_DST;
      S_RD_DST: begin
        src_op_d = reg_rd_data;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        src_op_d = alu_source;
        dst_op_d = alu_dest_in;
        result_d = alu_dest_out;
        if (op_q == OP_ADD || op_q == OP_ADDC)
          flags_d = {(s_msb == d_msb) && (r_msb != d_msb), r_msb, r_zero, alu_carry_out};
        else if (op_q == OP_SUB || op_q == OP_SUBC || op_q == OP_CMP)
          flags_d = {(s_msb != d_msb) && (r_msb != d_msb), r_msb, r_zero, alu_carry_out};
        else if (op_q == OP_AND || op_q == OP_BIT)
          flags_d = {1'b0, r_msb, r_zero, ~r_zero};
        else if (op_q == OP_XOR)
          flags_d = {s_msb & d_msb, r_msb, r_zero, ~r_zero};
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      S_ILL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d   = (state_d == S_IDLE);
    rd_addr_d = (state_d == S_RD_SRC) ? src_d : (state_d == S_RD_DST) ? dst_d : '0;
    alu_op_d  = (state_d == S_EXEC) ? map_op(op_d) : '0;
    wr_en_d   = (state_d == S_WB) && (op_d != OP_CMP) && (op_d != OP_BIT);
    done_d    = (state_d == S_WB);
    illegal_d = (state_d == S_ILL);
  end

  assign ready        = ready_q;
  assign reg_rd_addr  = rd_addr_q;
  assign reg_wr_en    = wr_en_q;
  assign reg_wr_addr  = dst_q;
  assign reg_wr_data  = result_q;
  assign alu_opcode   = alu_op_q;
  assign alu_carry_in = flags_q[0];
  assign flags        = flags_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_yam430_alu_seq.sv
// Bench for yam430_alu_seq: register-file and ALU models around the DUT, a vector table,
// hand-written multi-cycle sequences and randomized instructions against a reference model.
module tb_yam430_alu_seq;

  logic       clk, rst_n, start, ready;
  logic [3:0] opcode_in, src_reg_in, dst_reg_in, reg_rd_addr, reg_wr_addr, alu_opcode, flags;
  logic [7:0] reg_rd_data, reg_wr_data, alu_source, alu_dest_in, alu_dest_out;
  logic       reg_wr_en, alu_carry_in, alu_carry_out, done, illegal;

  logic [7:0] regs [16];
  logic [3:0] cur_flags;
  int checks = 0;
  int failures = 0;

  yam430_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .opcode_in(opcode_in), .src_reg_in(src_reg_in), .dst_reg_in(dst_reg_in),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .alu_opcode(alu_opcode), .alu_source(alu_source), .alu_dest_in(alu_dest_in),
    .alu_carry_in(alu_carry_in), .alu_dest_out(alu_dest_out), .alu_carry_out(alu_carry_out),
    .flags(flags), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file: data appears the cycle after the address.
  always @(posedge clk) reg_rd_data <= regs[reg_rd_addr];

  // Combinational ALU as seen by the sequencer.
  always_comb begin
    alu_dest_out  = '0;
    alu_carry_out = 1'b0;
    case (alu_opcode)
      4'd4:  alu_dest_out = alu_source;
      4'd5:  {alu_carry_out, alu_dest_out} = {1'b0, alu_dest_in} + {1'b0, alu_source};
      4'd6:  {alu_carry_out, alu_dest_out} = {1'b0, alu_dest_in} + {1'b0, alu_source} + 9'(alu_carry_in);
      4'd7:  {alu_carry_out, alu_dest_out} = {1'b0, alu_dest_in} + {1'b0, ~alu_source} + 9'(alu_carry_in);
      4'd8:  {alu_carry_out, alu_dest_out} = {1'b0, alu_dest_in} + {1'b0, ~alu_source} + 9'd1;
      4'd12: alu_dest_out = alu_dest_in & ~alu_source;
      4'd13: alu_dest_out = alu_dest_in | alu_source;
      4'd14: alu_dest_out = alu_dest_in ^ alu_source;
      4'd15: alu_dest_out = alu_dest_in & alu_source;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: result, write-back, flags and latency from the instruction rules.
  function automatic void ref_model(input logic [3:0] op, input logic [7:0] s, input logic [7:0] d,
                                    input logic [3:0] fl, output logic [7:0] res, output logic wr,
                                    output logic [3:0] flo, output int lat, output logic ill);
    int   sum;
    logic c, z, n, v;
    ill = (op < 4) || (op == 10);
    flo = fl; res = '0; wr = 1'b0; lat = 0; sum = 0; c = 1'b0;
    if (ill) return;
    lat = (op == 4) ? 3 : 4;
    wr  = !(op == 9 || op == 11);
    case (op)
      4'd4: res = s;
      4'd5, 4'd6: begin
        sum = int'(s) + int'(d) + ((op == 6) ? int'(fl[0]) : 0);
        res = sum[7:0]; c = (sum > 255);
      end
      4'd7, 4'd8, 4'd9: begin
        sum = int'(d) - int'(s) - ((op == 7) ? (1 - int'(fl[0])) : 0);
        res = sum[7:0]; c = (sum >= 0);
      end
      4'd11, 4'd15: res = s & d;
      4'd12: res = d & ~s;
      4'd13: res = d | s;
      default: res = s ^ d;
    endcase
    z = (res == 0);
    n = res[7];
    if (op == 5 || op == 6)      begin v = (s[7] == d[7]) && (n != d[7]); flo = {v, n, z, c}; end
    else if (op >= 7 && op <= 9) begin v = (s[7] != d[7]) && (n != d[7]); flo = {v, n, z, c}; end
    else if (op == 11 || op == 15) flo = {1'b0, n, z, ~z};
    else if (op == 14)             flo = {s[7] & d[7], n, z, ~z};
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    return (op == 9) ? 4'd8 : (op == 11) ? 4'd15 : op;
  endfunction

  // Issue one instruction from an idle cycle and observe six cycles after the accepting edge.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] src,
                           input logic [3:0] dst, input logic [7:0] exp_res, input logic exp_wr,
                           input logic [3:0] exp_fl, input int exp_lat, input logic exp_ill);
    int done_cnt = 0, done_k = 0, ill_cnt = 0, ill_k = 0, wr_cnt = 0;
    int rd_bad = 0, aop_bad = 0;
    logic [3:0] wa = '0;
    logic [7:0] wd = '0;
    logic [3:0] exp_rd;
    start = 1'b1; opcode_in = op; src_reg_in = src; dst_reg_in = dst;
    @(posedge clk); #1;
    start = 1'b0; opcode_in = '0; src_reg_in = '0; dst_reg_in = '0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (done)    begin done_cnt++; done_k = k; end
      if (illegal) begin ill_cnt++;  ill_k = k;  end
      if (reg_wr_en) begin wr_cnt++; wa = reg_wr_addr; wd = reg_wr_data; regs[reg_wr_addr] = reg_wr_data; end
      exp_rd = 4'd0;
      if (!exp_ill && k == 1) exp_rd = src;
      if (!exp_ill && k == 2 && op != 4) exp_rd = dst;
      if (reg_rd_addr != exp_rd) rd_bad++;
      if (!exp_ill && k == exp_lat - 1) begin
        if (alu_opcode != alu_op_of(op)) aop_bad++;
      end else if (alu_opcode != 4'd0) aop_bad++;
    end
    if (exp_ill) begin
      check({tag, " illegal_pulses"}, ill_cnt, 1);
      check({tag, " illegal_cycle"}, ill_k, 1);
      check({tag, " done_pulses"}, done_cnt, 0);
    end else begin
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " done_latency"}, done_k, exp_lat);
      check({tag, " illegal_pulses"}, ill_cnt, 0);
      check({tag, " alu_opcode"}, aop_bad, 0);
      if (exp_wr) begin
        check({tag, " wr_addr"}, wa, dst);
        check({tag, " wr_data"}, wd, exp_res);
      end
    end
    check({tag, " wr_count"}, wr_cnt, exp_wr ? 1 : 0);
    check({tag, " rd_addr"}, rd_bad, 0);
    check({tag, " flags"}, flags, exp_fl);
    check({tag, " ready_after"}, ready, 1);
    cur_flags = exp_fl;
  endtask

  typedef struct {
    logic [3:0] op, src, dst;
    logic [7:0] sval, dval, res;
    logic       wr;
    logic [3:0] fl;
    int         lat;
    logic       ill;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [7:0] e_res;
    logic       e_wr, e_ill;
    logic [3:0] e_fl, op;
    logic [3:0] legal_ops [11];
    int         e_lat, dk, wk;

    tbl[0]  = '{4'd5,  4'd1,  4'd2,  8'h01, 8'h7F, 8'h80, 1'b1, 4'b1100, 4, 1'b0};
    tbl[1]  = '{4'd9,  4'd3,  4'd4,  8'h55, 8'h55, 8'h00, 1'b0, 4'b0011, 4, 1'b0};
    tbl[2]  = '{4'd6,  4'd7,  4'd8,  8'h00, 8'hFF, 8'h00, 1'b1, 4'b0011, 4, 1'b0};
    tbl[3]  = '{4'd14, 4'd9,  4'd10, 8'h80, 8'h80, 8'h00, 1'b1, 4'b1010, 4, 1'b0};
    tbl[4]  = '{4'd4,  4'd5,  4'd6,  8'hA5, 8'h3C, 8'hA5, 1'b1, 4'b1010, 3, 1'b0};
    tbl[5]  = '{4'd8,  4'd11, 4'd12, 8'h01, 8'h00, 8'hFF, 1'b1, 4'b0100, 4, 1'b0};
    tbl[6]  = '{4'd7,  4'd13, 4'd14, 8'h10, 8'h30, 8'h1F, 1'b1, 4'b0001, 4, 1'b0};
    tbl[7]  = '{4'd15, 4'd1,  4'd15, 8'h01, 8'hF0, 8'h00, 1'b1, 4'b0010, 4, 1'b0};
    tbl[8]  = '{4'd11, 4'd2,  4'd3,  8'h81, 8'h80, 8'h80, 1'b0, 4'b0101, 4, 1'b0};
    tbl[9]  = '{4'd12, 4'd4,  4'd5,  8'h0F, 8'hFF, 8'hF0, 1'b1, 4'b0101, 4, 1'b0};
    tbl[10] = '{4'd13, 4'd6,  4'd7,  8'h0F, 8'h30, 8'h3F, 1'b1, 4'b0101, 4, 1'b0};
    tbl[11] = '{4'd5,  4'd8,  4'd8,  8'h40, 8'h40, 8'h80, 1'b1, 4'b1100, 4, 1'b0};
    tbl[12] = '{4'd2,  4'd1,  4'd2,  8'h11, 8'h22, 8'h00, 1'b0, 4'b1100, 0, 1'b1};
    tbl[13] = '{4'd10, 4'd3,  4'd4,  8'h11, 8'h22, 8'h00, 1'b0, 4'b1100, 0, 1'b1};
    legal_ops = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    for (int i = 0; i < 16; i++) regs[i] = '0;
    rst_n = 1'b0; start = 1'b0; opcode_in = '0; src_reg_in = '0; dst_reg_in = '0;
    cur_flags = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", ready, 1);
    check("reset flags", flags, 0);
    check("reset outputs", {done, illegal, reg_wr_en, reg_rd_addr, alu_opcode, alu_source, alu_dest_in}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: flags chain from one row to the next.
    for (int i = 0; i < 14; i++) begin
      regs[tbl[i].src] = tbl[i].sval;
      regs[tbl[i].dst] = tbl[i].dval;
      run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].src, tbl[i].dst,
                tbl[i].res, tbl[i].wr, tbl[i].fl, tbl[i].lat, tbl[i].ill);
    end

    // MOV with Start held high throughout: the follow-on ADD is taken only in the next idle cycle.
    regs[5] = 8'hA5; regs[6] = 8'h00; regs[1] = 8'h10; regs[2] = 8'h20;
    start = 1'b1; opcode_in = 4'd4; src_reg_in = 4'd5; dst_reg_in = 4'd6;
    @(posedge clk); #1;
    opcode_in = 4'd5; src_reg_in = 4'd1; dst_reg_in = 4'd2;
    dk = 0; wk = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 5) start = 1'b0;
      if (k == 4) check("held ready_idle", ready, 1);
      if (done) begin
        dk++;
        check($sformatf("held done_cycle%0d", dk), k, (dk == 1) ? 3 : 8);
      end
      if (reg_wr_en) begin
        wk++;
        check($sformatf("held wr%0d", wk), {reg_wr_addr, reg_wr_data}, (wk == 1) ? {4'd6, 8'hA5} : {4'd2, 8'h30});
        regs[reg_wr_addr] = reg_wr_data;
      end
    end
    check("held done_total", dk, 2);
    check("held wr_total", wk, 2);
    check("held flags", flags, 4'b0000);
    cur_flags = flags == 4'b0000 ? 4'b0000 : 4'b0000;

    // Reset during EXEC of a SUB aborts it without write-back.
    regs[1] = 8'h05; regs[2] = 8'h09;
    start = 1'b1; opcode_in = 4'd8; src_reg_in = 4'd1; dst_reg_in = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort in_exec", alu_opcode, 4'd8);
    rst_n = 1'b0;
    #1;
    check("abort ready", ready, 1);
    check("abort flags", flags, 0);
    check("abort outputs", {reg_wr_en, done, alu_opcode}, 0);
    wk = 0;
    repeat (2) begin @(posedge clk); #1; if (reg_wr_en) wk++; end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (reg_wr_en) wk++;
    check("abort no_write", wk, 0);
    check("abort reg_kept", regs[2], 8'h09);
    cur_flags = '0;
    ref_model(4'd5, regs[1], regs[2], cur_flags, e_res, e_wr, e_fl, e_lat, e_ill);
    run_instr("post_reset add", 4'd5, 4'd1, 4'd2, e_res, e_wr, e_fl, e_lat, e_ill);

    // Randomized instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 3; j++) regs[$urandom_range(0, 15)] = 8'($urandom);
      op = legal_ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) op = ($urandom_range(0, 4) == 4) ? 4'd10 : 4'($urandom_range(0, 3));
      src_reg_in = 4'($urandom_range(0, 15));
      dst_reg_in = 4'($urandom_range(0, 15));
      begin
        logic [3:0] s_r, d_r;
        s_r = src_reg_in; d_r = dst_reg_in;
        ref_model(op, regs[s_r], regs[d_r], cur_flags, e_res, e_wr, e_fl, e_lat, e_ill);
        run_instr($sformatf("rand%0d op%0d", n, op), op, s_r, d_r, e_res, e_wr, e_fl, e_lat, e_ill);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
